ps2_key_tracker: RTL

PS/2 keyboard front end that supplies the held-key codes consumed by the display/game logic. It samples the keyboard's PS/2 clock/data lines and deframes 11-bit device-to-host frames. It interprets Set-2 make, break (F0) and extended (E0) sequences, and maintains up to two concurrently held keys on `keycode1`/`keycode2`, so both paddles can move at once. It sits between the board PS/2 pins and the pixel generator.

---
 rtl/ps2_key_tracker_pkg.sv | 51 +++++
 rtl/ps2_rx_frame.sv | 179 +++++++++++++++++
 rtl/ps2_key_tracker.sv | 99 +++++++++
 3 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// ============================================================================
// Module  : ps2_key_tracker_pkg
// Brief   : Shared PS/2 byte constants, game key codes and FSM encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_key_tracker_pkg;

  localparam logic [7:0] PS2_BRK      = 8'hF0;
  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] KEY_NONE     = 8'h00;

  // Keyboard status/response bytes that never represent a key.
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_OVERRUN  = 8'hFF;

  localparam logic [7:0] KEY_W        = 8'h1D;
  localparam logic [7:0] KEY_S        = 8'h1B;
  localparam logic [7:0] KEY_O        = 8'h44;
  localparam logic [7:0] KEY_L        = 8'h4B;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_e;

  typedef enum logic [1:0] {
    DEC_NORM    = 2'd0,
    DEC_BRK     = 2'd1,
    DEC_EXT     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } decode_state_e;

  function automatic logic is_non_key(input logic [7:0] b);
    case (b)
      KEY_NONE, PS2_BAT_OK, PS2_ECHO, PS2_ACK,
      PS2_BAT_FAIL, PS2_RESEND, PS2_OVERRUN: is_non_key = 1'b1;
      default:                               is_non_key = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ============================================================================
// Module  : ps2_rx_frame
// Brief   : PS/2 line conditioning and 11-bit device-to-host frame receiver.
//           Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_frame
  import ps2_key_tracker_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       frame_err_o
);

  localparam int            FW        = $clog2(FILTER_LEN + 1);
  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC);

  logic [1:0] raw_w;
  logic [1:0] flt_w;
  logic       clk_flt_prev_q;
  logic       fall_w;
  logic       data_w;
  logic       par_ok_w;

  frame_state_e  state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  assign raw_w = {ps2_data_i, ps2_clk_i};

  // Line 0 is the PS/2 clock, line 1 the PS/2 data; both idle high.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0]    sync_q;
      logic          flt_q;
      logic [FW-1:0] cnt_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          sync_q <= 2'b11;
          flt_q  <= 1'b1;
          cnt_q  <= '0;
        end else begin
          sync_q <= {sync_q[0], raw_w[gi]};
          if (sync_q[1] == flt_q) begin
            cnt_q <= '0;
          end else if (cnt_q == FILT_LAST) begin
            flt_q <= sync_q[1];
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + FW'(1);
          end
        end
      end

      assign flt_w[gi] = flt_q;
    end
  endgenerate

  assign fall_w = clk_flt_prev_q & ~flt_w[0];
  assign data_w = flt_w[1];

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok_w = ^{shift_q, par_q};
`else
  logic unused_par;
  assign par_ok_w   = 1'b1;
  assign unused_par = par_q;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    to_cnt_d     = to_cnt_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == FR_IDLE || fall_w) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    case (state_q)
      FR_IDLE: begin
        if (fall_w) begin
          if (!data_w) begin
            state_d   = FR_DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      FR_DATA: begin
        if (fall_w) begin
          shift_d   = {data_w, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = FR_PARITY;
        end
      end
      FR_PARITY: begin
        if (fall_w) begin
          par_d   = data_w;
          state_d = FR_STOP;
        end
      end
      FR_STOP: begin
        if (fall_w) begin
          if (data_w && par_ok_w) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = FR_IDLE;
        end
      end
      default: state_d = FR_IDLE;
    endcase

    // A fall in the same cycle keeps the frame alive.
    if (state_q != FR_IDLE && !fall_w && to_cnt_q == TO_LIMIT) begin
      frame_err_d = 1'b1;
      state_d     = FR_IDLE;
      to_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_flt_prev_q <= 1'b1;
      state_q        <= FR_IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      par_q          <= 1'b0;
      to_cnt_q       <= '0;
      rx_byte_q      <= '0;
      byte_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      clk_flt_prev_q <= flt_w[0];
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      par_q          <= par_d;
      to_cnt_q       <= to_cnt_d;
      rx_byte_q      <= rx_byte_d;
      byte_valid_q   <= byte_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign rx_byte_o    = rx_byte_q;
  assign frame_err_o  = frame_err_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// Module  : ps2_key_tracker
// Brief   : PS/2 Set-2 decoder tracking up to two concurrently held keys.
//           Optional parity checking via PS2_PARITY_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode1,
  output logic [7:0] keycode2,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  logic       rx_valid_w;
  logic [7:0] rx_byte_w;
  logic       rx_err_w;

  decode_state_e dec_q, dec_d;
  logic [7:0]    kc1_q, kc1_d;
  logic [7:0]    kc2_q, kc2_d;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk_i        (vga_clk),
    .rst_ni       (sys_rst_n),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_valid_o (rx_valid_w),
    .rx_byte_o    (rx_byte_w),
    .frame_err_o  (rx_err_w)
  );

  always_comb begin
    dec_d = dec_q;
    kc1_d = kc1_q;
    kc2_d = kc2_q;
    if (rx_valid_w) begin
      case (dec_q)
        DEC_NORM: begin
          if (rx_byte_w == PS2_BRK) begin
            dec_d = DEC_BRK;
          end else if (rx_byte_w == PS2_EXT) begin
            dec_d = DEC_EXT;
          end else if (!is_non_key(rx_byte_w) &&
                       rx_byte_w != kc1_q && rx_byte_w != kc2_q) begin
            // Fill the first empty slot; a third key is dropped.
            if (kc1_q == KEY_NONE) begin
              kc1_d = rx_byte_w;
            end else if (kc2_q == KEY_NONE) begin
              kc2_d = rx_byte_w;
            end
          end
        end
        DEC_BRK: begin
          if (kc1_q == rx_byte_w) kc1_d = KEY_NONE;
          if (kc2_q == rx_byte_w) kc2_d = KEY_NONE;
          dec_d = DEC_NORM;
        end
        DEC_EXT: dec_d = (rx_byte_w == PS2_BRK) ? DEC_EXT_BRK : DEC_NORM;
        default: dec_d = DEC_NORM;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dec_q <= DEC_NORM;
      kc1_q <= KEY_NONE;
      kc2_q <= KEY_NONE;
    end else begin
      dec_q <= dec_d;
      kc1_q <= kc1_d;
      kc2_q <= kc2_d;
    end
  end

  assign keycode1   = kc1_q;
  assign keycode2   = kc2_q;
  assign byte_valid = rx_valid_w;
  assign rx_byte    = rx_byte_w;
  assign frame_err  = rx_err_w;

endmodule

`default_nettype wire
